// File: rtl/spi_slave_byte_if.sv
// Pin bundle for one SPI byte slave: the SPI wires plus the byte-wide host side.
// The master modport is the view of whoever drives SCK/CS/MOSI and offers TX bytes.
interface spi_slave_byte_if;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic       busy;

    modport master (
        output sck, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, busy
    );

    modport slave (
        input  sck, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, rx_data, rx_valid, tx_ready, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave_byte_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by a registered
// copy of the synchronized level used to flag rising and falling edges.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Preloading to the idle level keeps reset release from looking like an edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;
endmodule

// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte slave, oversampled by wb_clk_i: MSB-first 8-bit frames,
// back-to-back bytes per CS assertion, one-entry TX holding register.
module spi_slave_byte #(
    parameter logic [7:0] IDLE_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       sck_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_underrun_o,
    output logic       busy_o
);
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam logic [2:0] SETTLE_CYC = 3'(SYNC_STAGES + 1);

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;
    logic [2:0] settle_q, settle_d;
    logic       armed_q, armed_d;

    logic       sck_lvl, sck_rise, sck_fall;
    logic       cs_lvl, cs_rise, cs_fall;
    logic       mosi_lvl, mosi_rise, mosi_fall;
    logic       tx_load, handshake;
    logic [7:0] load_byte;
    logic       unused_sync;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .d_i(sck_i),
        .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .d_i(cs_n_i),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .d_i(mosi_i),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall};
    assign handshake   = tx_valid_i & ~hold_full_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        settle_d    = settle_q;
        armed_d     = armed_q;
        tx_load     = 1'b0;
        load_byte   = IDLE_BYTE;

        // A cs_n held low across reset reads as a falling edge once the
        // synchronizer refills; selection is only armed after cs_n is seen high.
        if (settle_q != SETTLE_CYC) begin
            settle_d = settle_q + 3'd1;
        end else if (cs_lvl) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (armed_q && cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = 3'd0;
                    tx_load   = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_lvl};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {rx_shift_q[6:0], mosi_lvl};
                        rx_valid_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end else begin
                        tx_load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A byte offered in the very cycle of a load bypasses the holding register.
        if (hold_full_q) begin
            load_byte = hold_q;
        end else if (handshake) begin
            load_byte = tx_data_i;
        end

        if (tx_load) begin
            tx_shift_d = load_byte;
            if (hold_full_q) begin
                hold_full_d = 1'b0;
            end else if (!handshake) begin
                underrun_d = 1'b1;
            end
        end else if (handshake) begin
            hold_d      = tx_data_i;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'd0;
            tx_shift_q  <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            settle_q    <= 3'd0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    assign miso_oe_o     = (state_q == ACTIVE);
    assign busy_o        = (state_q == ACTIVE);
    assign miso_o        = (state_q == ACTIVE) & tx_shift_q[7];
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_ready_o    = ~hold_full_q;
    assign tx_underrun_o = underrun_q;
endmodule

// File: tb/tb_spi_slave_byte.sv
// Scoreboard bench for spi_slave_byte: a behavioural SPI master plus a model
// of the TX holding register predicts every RX byte, MISO byte and underrun.
`timescale 1ns/1ps
module tb_spi_slave_byte;
    localparam logic [7:0] IDLE_B = 8'hFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_byte_if bus();

    spi_slave_byte #(.IDLE_BYTE(IDLE_B), .SYNC_STAGES(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .sck_i(bus.sck), .cs_n_i(bus.cs_n), .mosi_i(bus.mosi),
        .miso_o(bus.miso), .miso_oe_o(bus.miso_oe),
        .rx_data_o(bus.rx_data), .rx_valid_o(bus.rx_valid),
        .tx_data_i(bus.tx_data), .tx_valid_i(bus.tx_valid),
        .tx_ready_o(bus.tx_ready), .tx_underrun_o(bus.tx_underrun),
        .busy_o(bus.busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and holding-register model
    logic [7:0] rx_exp_q[$];
    logic [7:0] mon_exp;
    int         rx_cnt = 0;
    int         under_seen = 0;
    int         exp_under = 0;
    logic [7:0] hold_m = 8'h00;
    bit         hold_full_m = 1'b0;

    logic [7:0] mo_m[128];
    bit         push_en_m[128];
    logic [7:0] push_val_m[128];

    always @(negedge clk) begin
        if (!rst && bus.rx_valid) begin
            rx_cnt++;
            if (rx_exp_q.size() == 0) begin
                chk("rx_extra", {31'd0, bus.rx_valid}, 32'd0);
            end else begin
                mon_exp = rx_exp_q.pop_front();
                chk("rx_data", {24'd0, bus.rx_data}, {24'd0, mon_exp});
            end
        end
        if (!rst && bus.tx_underrun) under_seen++;
    end

    function automatic logic [7:0] model_load();
        if (hold_full_m) begin
            hold_full_m = 1'b0;
            return hold_m;
        end
        exp_under++;
        return IDLE_B;
    endfunction

    function automatic int ph(input bit jit);
        return jit ? 4 + int'($urandom_range(0, 1)) : 4;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] v);
        @(negedge clk);
        chk("tx_ready_pre", {31'd0, bus.tx_ready}, {31'd0, !hold_full_m});
        bus.tx_valid = 1'b1;
        bus.tx_data  = v;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("tx_ready_post", {31'd0, bus.tx_ready}, 32'd0);
        hold_m      = v;
        hold_full_m = 1'b1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_miso", {31'd0, bus.miso}, 32'd0);
        chk("rst_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
        chk("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        chk("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("rst_underrun", {31'd0, bus.tx_underrun}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    // Master: mode 0, MSB first; abort_bits<0 means full bytes, inj_byte<0 means no same-cycle offer
    task automatic spi_xfer(input int nbytes, input int abort_bits, input int inj_byte,
                            input logic [7:0] inj_val, input bit jit);
        logic [7:0] exp_m, nxt_m, got_m;
        int         nbits;
        bit         aborted;
        nbits   = 0;
        aborted = 1'b0;
        @(negedge clk);
        bus.sck  = 1'b0;
        bus.mosi = mo_m[0][7];
        bus.cs_n = 1'b0;
        exp_m    = model_load();
        cyc(6);
        chk("busy_active", {31'd0, bus.busy}, 32'd1);
        chk("miso_oe_active", {31'd0, bus.miso_oe}, 32'd1);
        for (int b = 0; b < nbytes; b++) begin
            got_m = 8'h00;
            nxt_m = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                if (nbits == abort_bits) begin
                    aborted = 1'b1;
                    break;
                end
                got_m[i] = bus.miso;
                bus.sck  = 1'b1;
                if (i == 0) rx_exp_q.push_back(mo_m[b]);
                nbits++;
                cyc(ph(jit));
                bus.sck = 1'b0;
                if (i > 0) begin
                    bus.mosi = mo_m[b][i-1];
                    if (i == 4 && push_en_m[b] && !hold_full_m) begin
                        cyc(1);
                        chk("tx_ready_mid", {31'd0, bus.tx_ready}, 32'd1);
                        bus.tx_valid = 1'b1;
                        bus.tx_data  = push_val_m[b];
                        cyc(1);
                        bus.tx_valid = 1'b0;
                        hold_m       = push_val_m[b];
                        hold_full_m  = 1'b1;
                        cyc(ph(jit) - 2);
                    end else begin
                        cyc(ph(jit));
                    end
                end else begin
                    if (b + 1 < nbytes) bus.mosi = mo_m[b+1][7];
                    if (b == inj_byte) begin
                        cyc(2);
                        bus.tx_valid = 1'b1;
                        bus.tx_data  = inj_val;
                        cyc(1);
                        bus.tx_valid = 1'b0;
                        chk("inj_ready_stays", {31'd0, bus.tx_ready}, 32'd1);
                        nxt_m = inj_val;
                        cyc(2);
                        chk("inj_ready_after", {31'd0, bus.tx_ready}, 32'd1);
                    end else begin
                        nxt_m = model_load();
                        cyc(ph(jit));
                    end
                end
            end
            if (aborted) break;
            chk("miso_byte", {24'd0, got_m}, {24'd0, exp_m});
            exp_m = nxt_m;
        end
        bus.cs_n = 1'b1;
        cyc(6);
        chk("busy_idle", {31'd0, bus.busy}, 32'd0);
        chk("miso_oe_idle", {31'd0, bus.miso_oe}, 32'd0);
        chk("miso_idle", {31'd0, bus.miso}, 32'd0);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx_before, under_before;
        rst          = 1'b1;
        bus.cs_n     = 1'b1;
        bus.sck      = 1'b0;
        bus.mosi     = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        for (int k = 0; k < 128; k++) begin
            push_en_m[k] = 1'b0;
            push_val_m[k] = 8'h00;
            mo_m[k] = 8'h00;
        end
        cyc(4);
        chk_reset_outputs();
        rst = 1'b0;
        cyc(8);

        // Single byte with a preloaded TX byte
        push_tx(8'h3C);
        mo_m[0] = 8'hA5;
        spi_xfer(1, -1, -1, 8'h00, 1'b0);
        chk("rx_hold_a5", {24'd0, bus.rx_data}, 32'h0000_00A5);

        // Three-byte burst, TX queued during bytes 0 and 2
        push_tx(8'h10);
        under_before = under_seen;
        mo_m[0] = 8'h01; mo_m[1] = 8'h02; mo_m[2] = 8'h03;
        push_en_m[0] = 1'b1; push_val_m[0] = 8'h20;
        push_en_m[2] = 1'b1; push_val_m[2] = 8'h30;
        spi_xfer(3, -1, -1, 8'h00, 1'b0);
        push_en_m[0] = 1'b0; push_en_m[2] = 1'b0;
        chk("burst_underruns", under_seen - under_before, 32'd1);
        chk("burst_ready", {31'd0, bus.tx_ready}, 32'd1);

        // Deselect after five bits, then a clean transfer
        rx_before = rx_cnt;
        mo_m[0] = 8'hF0;
        spi_xfer(1, 5, -1, 8'h00, 1'b0);
        chk("abort_no_rx", rx_cnt - rx_before, 32'd0);
        push_tx(8'hC3);
        mo_m[0] = 8'h5A;
        spi_xfer(1, -1, -1, 8'h00, 1'b0);
        chk("after_abort_rx", rx_cnt - rx_before, 32'd1);

        // Offer coinciding with a byte-boundary load, holding register empty
        under_before = under_seen;
        mo_m[0] = 8'h11; mo_m[1] = 8'h22;
        spi_xfer(2, -1, 0, 8'h77, 1'b0);
        chk("inj_underruns", under_seen - under_before, 32'd2);

        // Reset mid-byte with cs_n held low
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.mosi = 1'b1;
        void'(model_load());
        cyc(6);
        for (int k = 0; k < 3; k++) begin
            bus.sck = 1'b1; cyc(4);
            bus.sck = 1'b0; cyc(4);
        end
        push_tx(8'h66);
        rst = 1'b1;
        cyc(3);
        chk_reset_outputs();
        hold_full_m = 1'b0;
        rst = 1'b0;
        rx_before = rx_cnt;
        cyc(2);
        for (int k = 0; k < 10; k++) begin
            bus.sck  = 1'b1; cyc(4);
            bus.sck  = 1'b0;
            bus.mosi = ~bus.mosi; cyc(4);
            chk("rst_hold_idle", {31'd0, bus.busy}, 32'd0);
        end
        chk("rst_hold_oe", {31'd0, bus.miso_oe}, 32'd0);
        chk("rst_hold_no_rx", rx_cnt - rx_before, 32'd0);
        bus.cs_n = 1'b1;
        cyc(8);
        push_tx(8'h9C);
        mo_m[0] = 8'hE7;
        spi_xfer(1, -1, -1, 8'h00, 1'b0);
        chk("rst_recover_rx", rx_cnt - rx_before, 32'd1);

        // 1000 random bytes with jittered SCK phases
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < 100; k++) begin
                mo_m[k]       = 8'($urandom_range(0, 255));
                push_en_m[k]  = ($urandom_range(0, 3) != 0);
                push_val_m[k] = 8'($urandom_range(0, 255));
            end
            spi_xfer(100, -1, -1, 8'h00, 1'b1);
        end

        cyc(10);
        chk("rx_pending", rx_exp_q.size(), 32'd0);
        chk("underrun_total", under_seen, exp_under);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
